// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl: synchronises and debounces push-buttons, captures presses and raises a masked level irq.
module button_irq_ctrl #(
    parameter int WIDTH            = 4,
    parameter int CNT_W            = 20,
    parameter int DEBOUNCE_DEFAULT = 50000,
    parameter int PRESS_LEVEL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam logic [WIDTH-1:0] IDLE    = (PRESS_LEVEL != 0) ? '0 : '1;
    localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEBOUNCE_DEFAULT);

    logic [WIDTH-1:0] sync1_q, sync2_q, deb_q, deb_d, mask_q, mask_d, edge_q, edge_d, press;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] period_q, period_d, pm1;
    logic [31:0]      rd_d;
    logic             irq_d, wr, wr_mask, wr_edge, wr_per;
    logic             unused_wd;

    assign unused_wd = &{1'b0, writedata};
    assign wr        = chipselect && write;
    assign wr_mask   = wr && address == 2'd1;
    assign wr_edge   = wr && address == 2'd2;
    assign wr_per    = wr && address == 2'd3;
    // A period of 0 behaves as 1: the debounced state follows one cycle after the sync output.
    assign pm1       = (period_q == '0) ? '0 : period_q - 1'b1;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!wr_per && sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == pm1) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press    = (deb_q ^ deb_d) & ((PRESS_LEVEL != 0) ? deb_d : ~deb_d);
    assign edge_d   = (edge_q & ~(wr_edge ? writedata[WIDTH-1:0] : '0)) | press;
    assign mask_d   = wr_mask ? writedata[WIDTH-1:0] : mask_q;
    assign period_d = wr_per ? writedata[CNT_W-1:0] : period_q;
    assign irq_d    = |(edge_q & mask_q);

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0:    rd_d[WIDTH-1:0] = deb_q;
            2'd1:    rd_d[WIDTH-1:0] = mask_q;
            2'd2:    rd_d[WIDTH-1:0] = edge_q;
            default: rd_d[CNT_W-1:0] = period_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= IDLE;
            sync2_q  <= IDLE;
            deb_q    <= IDLE;
            mask_q   <= '0;
            edge_q   <= '0;
            period_q <= PER_RST;
            readdata <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            period_q <= period_d;
            readdata <= rd_d;
            irq      <= irq_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end
endmodule

// File: tb/tb_button_irq_ctrl.sv
// tb_button_irq_ctrl: scoreboard bench with a run-length debounce reference model.
module tb_button_irq_ctrl;
    localparam int W  = 4;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          reset, chipselect, write, irq;
    logic [1:0]    address;
    logic [31:0]   writedata, readdata;
    logic [W-1:0]  in_port;

    always #5 clk = ~clk;

    button_irq_ctrl dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int checks = 0, passed = 0, cyc = 0;

    // Reference: a button's debounced value adopts the synced value once they have
    // disagreed for P consecutive cycles; a PERIOD write restarts every run.
    logic [W-1:0] s1, s2, deb, msk, edg, old_deb;
    int unsigned  per, p;
    int           run [W];
    logic         mwr;
    exp_t         me, ce;

    initial forever begin
        @(posedge clk);
        cyc++;
        mwr = chipselect && write;
        me = '0;
        case (address)
            2'd0: me.rd[W-1:0] = deb;
            2'd1: me.rd[W-1:0] = msk;
            2'd2: me.rd[W-1:0] = edg;
            default: me.rd[CW-1:0] = per[CW-1:0];
        endcase
        me.irq = |(edg & msk);
        if (reset) begin
            s1 = '1; s2 = '1; deb = '1; msk = '0; edg = '0; per = 50000;
            for (int i = 0; i < W; i++) run[i] = 0;
            me = '0;
        end else begin
            old_deb = deb;
            p = (per == 0) ? 1 : per;
            for (int i = 0; i < W; i++) begin
                if (mwr && address == 2'd3) run[i] = 0;
                else if (s2[i] == deb[i]) run[i] = 0;
                else if (run[i] + 1 >= p) begin deb[i] = s2[i]; run[i] = 0; end
                else run[i]++;
            end
            s2 = s1;
            s1 = in_port;
            edg = ((mwr && address == 2'd2) ? (edg & ~writedata[W-1:0]) : edg) | (old_deb & ~deb);
            if (mwr && address == 2'd1) msk = writedata[W-1:0];
            if (mwr && address == 2'd3) per = writedata[CW-1:0];
        end
        q.push_back(me);
    end

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            ce = q.pop_front();
            checks += 2;
            if (readdata === ce.rd) passed++;
            else $display("FAIL readdata cyc=%0d got=%h exp=%h", cyc, readdata, ce.rd);
            if (irq === ce.irq) passed++;
            else $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq, ce.irq);
        end
    end

    task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        reset = r; chipselect = w; write = w; address = a; writedata = d;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0; in_port = '1;
        step(1'b1, 1'b0, 2'd0, 0);
        step(1'b1, 1'b0, 2'd0, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 2);
        wr(2'd3, 4); wr(2'd1, 1);
        in_port[0] = 1'b0;
        for (int k = 0; k < 10; k++) rd(2'(k % 3), 1);
        in_port[0] = 1'b1; rd(2'd0, 8);
        in_port[1] = 1'b0; rd(2'd0, 3); in_port[1] = 1'b1; rd(2'd0, 6); rd(2'd2, 4);
        in_port[1] = 1'b0; rd(2'd0, 4); in_port[1] = 1'b1; rd(2'd0, 8); rd(2'd2, 2);
        wr(2'd2, 2); in_port[2] = 1'b0; rd(2'd0, 8); rd(2'd2, 2);
        wr(2'd1, 4); wr(2'd2, 4); rd(2'd2, 3);
        wr(2'd1, 1); rd(2'd1, 3);
        in_port[2] = 1'b1; rd(2'd0, 8);
        wr(2'd1, 4); in_port[2] = 1'b0;
        for (int k = 0; k < 10; k++) wr(2'd2, 4);
        rd(2'd2, 4);
        wr(2'd3, 0); wr(2'd1, 32'hF);
        in_port[3] = 1'b0; rd(2'd0, 4); in_port[3] = 1'b1; rd(2'd0, 4);
        in_port = '1; rd(2'd0, 4); in_port = '0; rd(2'd2, 5);
        step(1'b1, 1'b0, 2'd2, 0);
        rd(2'd2, 2); rd(2'd3, 2); rd(2'd0, 2);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 15) == 0) in_port[i] = ~in_port[i];
            address = 2'($urandom_range(0, 3));
            writedata = (address == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
            chipselect = ($urandom_range(0, 3) == 0);
            write = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rd(2'd0, 3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
